// File: rtl/bus_timer_irq.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer_irq
// Purpose  : Memory-mapped 16-bit interval timer on the 6502 CPU bus.
//            Decodes a 16-byte register window, returns read data
//            combinationally, can stretch accesses with wait states
//            (rdy low), and raises an active-low interrupt when the
//            down-counter expires.
// Ports    : clk      - CPU clock; all state changes on the rising edge
//            res      - asynchronous active-high reset
//            add_bus  - CPU address bus [15:0]
//            wr_data  - CPU write data [7:0]
//            write_en - CPU write strobe, active high
//            rd_data  - read data to CPU [7:0], 8'h00 when not selected
//            rdy      - ready to CPU, low stalls the CPU
//            IRQ      - interrupt request, active low, registered
// Config   : BUS_TIMER_WAIT_EN - when defined, the wait-state FSM is built
//            and WAIT_STATES is honoured; otherwise rdy is tied high.
// Revision : 1.0 - initial release
// ============================================================================
module bus_timer_irq #(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic [15:0] add_bus,
    input  logic [7:0]  wr_data,
    input  logic        write_en,
    output logic [7:0]  rd_data,
    output logic        rdy,
    output logic        IRQ
);

    localparam logic [2:0] c_wait_states = 3'(WAIT_STATES);

    logic       w_sel;
    logic [3:0] w_off;
    logic       w_rdy;
    logic       w_wr;
    logic       w_rd;
    logic       w_wr_lat_hi;
    logic       w_w1c;

    logic [15:0] r_counter;
    logic [15:0] r_latch;
    logic [7:0]  r_snap_hi;
    logic        r_en;
    logic        r_cont;
    logic        r_ie;
    logic        r_iflag;
    logic        r_irq_n;

    assign w_sel = (add_bus[15:4] == BASE_ADDR[15:4]);
    assign w_off = add_bus[3:0];

    // An access takes effect only on an edge where the CPU is not stalled.
    assign w_wr        = w_sel & w_rdy & write_en;
    assign w_rd        = w_sel & w_rdy & ~write_en;
    assign w_wr_lat_hi = w_wr & (w_off == 4'h3);
    assign w_w1c       = w_wr & (w_off == 4'h5) & wr_data[0];

`ifdef BUS_TIMER_WAIT_EN
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0] r_state;
    // Stall cycles still to go, counting the current WAIT cycle.
    logic [2:0] r_wcnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= c_st_idle;
            r_wcnt  <= 3'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // The IDLE cycle that sees sel is itself the first stall.
                    if (w_sel && (c_wait_states != 3'd0)) begin
                        if (c_wait_states == 3'd1) begin
                            r_state <= c_st_done;
                        end else begin
                            r_state <= c_st_wait;
                            r_wcnt  <= c_wait_states - 3'd1;
                        end
                    end
                end
                c_st_wait: begin
                    if (!w_sel) begin
                        r_state <= c_st_idle;
                    end else if (r_wcnt == 3'd1) begin
                        r_state <= c_st_done;
                    end else begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_rdy = 1'b1;
        case (r_state)
            c_st_idle: if (w_sel && (c_wait_states != 3'd0)) w_rdy = 1'b0;
            c_st_wait: if (w_sel) w_rdy = 1'b0;
            default:   w_rdy = 1'b1;
        endcase
    end
`else
    logic w_unused_wait;
    assign w_unused_wait = |c_wait_states;
    assign w_rdy         = 1'b1;
`endif

    assign rdy = w_rdy;
    assign IRQ = r_irq_n;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_counter <= 16'h0000;
            r_latch   <= 16'hFFFF;
            r_snap_hi <= 8'h00;
            r_en      <= 1'b0;
            r_cont    <= 1'b0;
            r_ie      <= 1'b0;
            r_iflag   <= 1'b0;
            r_irq_n   <= 1'b1;
        end else begin
            r_irq_n <= ~(r_iflag & r_ie);

            // Freeze the high byte at the low-byte read so a 16-bit read
            // is coherent even if the counter borrows in between.
            if (w_rd && (w_off == 4'h0)) r_snap_hi <= r_counter[15:8];

            if (w_wr && (w_off == 4'h2)) r_latch[7:0] <= wr_data;
            if (w_wr_lat_hi)             r_latch[15:8] <= wr_data;

            // Load beats expiry, expiry set beats W1C clear.
            if (w_wr_lat_hi) begin
                r_counter <= {wr_data, r_latch[7:0]};
                r_iflag   <= 1'b0;
            end else if (r_en && (r_counter == 16'h0000)) begin
                r_iflag <= 1'b1;
                if (r_cont) r_counter <= r_latch;
                else        r_en      <= 1'b0;
            end else begin
                if (r_en)  r_counter <= r_counter - 16'h0001;
                if (w_w1c) r_iflag   <= 1'b0;
            end

            // A CTRL write in the expiry cycle keeps the written EN.
            if (w_wr && (w_off == 4'h4)) begin
                r_en   <= wr_data[0];
                r_cont <= wr_data[1];
                r_ie   <= wr_data[2];
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (w_sel) begin
            case (w_off)
                4'h0:    rd_data = r_counter[7:0];
                4'h1:    rd_data = r_snap_hi;
                4'h2:    rd_data = r_latch[7:0];
                4'h3:    rd_data = r_latch[15:8];
                4'h4:    rd_data = {5'b00000, r_ie, r_cont, r_en};
                4'h5:    rd_data = {7'b0000000, r_iflag};
                default: rd_data = 8'h00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_timer_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_timer_irq
// Purpose  : Self-checking bench for bus_timer_irq. Directed sequences
//            (reset mid-access, one-shot, continuous, snapshot) followed by
//            random bus traffic, all compared every cycle against a
//            behavioural model of the register file and timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timer_irq;

    localparam logic [15:0] BASE = 16'hD000;
    localparam int          WS   = 2;
`ifdef BUS_TIMER_WAIT_EN
    localparam int EFF_WS = WS;
`else
    localparam int EFF_WS = 0;
`endif

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [15:0] add_bus = 16'h0000;
    logic [7:0]  wr_data = 8'h00;
    logic        write_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rdy;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_cnt;
    logic [15:0] m_lat;
    logic [7:0]  m_snap;
    logic        m_en, m_cont, m_ie, m_iflag, m_irq;
    int          m_ws;   // stall cycles already spent on the current access

    bus_timer_irq #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .clk      (clk),
        .res      (res),
        .add_bus  (add_bus),
        .wr_data  (wr_data),
        .write_en (write_en),
        .rd_data  (rd_data),
        .rdy      (rdy),
        .IRQ      (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 16'h0000; m_lat = 16'hFFFF; m_snap = 8'h00;
        m_en = 0; m_cont = 0; m_ie = 0; m_iflag = 0; m_irq = 1; m_ws = 0;
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (a[15:4] != BASE[15:4]) return 8'h00;
        case (a[3:0])
            4'h0: return m_cnt[7:0];
            4'h1: return m_snap;
            4'h2: return m_lat[7:0];
            4'h3: return m_lat[15:8];
            4'h4: return {5'd0, m_ie, m_cont, m_en};
            4'h5: return {7'd0, m_iflag};
            default: return 8'h00;
        endcase
    endfunction

    // One rising edge of the model, given the bus inputs of that cycle.
    function automatic void model_edge(input logic sel, input logic ok, input logic [3:0] off,
                                       input logic we, input logic [7:0] d);
        logic wr, rd, load, expire, w1c, irq_next;
        wr       = sel && ok && we;
        rd       = sel && ok && !we;
        load     = wr && off == 4'h3;
        w1c      = wr && off == 4'h5 && d[0];
        expire   = m_en && m_cnt == 16'h0000;
        irq_next = !(m_iflag && m_ie);

        if (!sel || ok) m_ws = 0;
        else            m_ws = m_ws + 1;

        if (rd && off == 4'h0) m_snap = m_cnt[15:8];

        if (load) begin
            m_cnt   = {d, m_lat[7:0]};
            m_iflag = 0;
        end else if (expire) begin
            m_iflag = 1;
            if (m_cont) m_cnt = m_lat;
            else        m_en  = 0;
        end else begin
            if (m_en) m_cnt = m_cnt - 1;
            if (w1c)  m_iflag = 0;
        end

        if (wr && off == 4'h2) m_lat[7:0]  = d;
        if (load)              m_lat[15:8] = d;
        if (wr && off == 4'h4) {m_ie, m_cont, m_en} = d[2:0];
        m_irq = irq_next;
    endfunction

    // Drive one bus cycle, check the outputs mid-cycle, advance the model.
    task automatic step(input logic [15:0] a, input logic we, input logic [7:0] d,
                        output logic done, output logic [7:0] q);
        logic sel, exp_rdy;
        @(negedge clk);
        add_bus = a; write_en = we; wr_data = d;
        #1;
        sel     = (a[15:4] == BASE[15:4]);
        exp_rdy = !sel || (m_ws >= EFF_WS);
        check("rdy", rdy, exp_rdy);
        check("rd_data", rd_data, model_rd(a));
        check("irq", IRQ, m_irq);
        q    = rd_data;
        done = sel && exp_rdy;
        @(posedge clk);
        model_edge(sel, exp_rdy, a[3:0], we, d);
    endtask

    task automatic idle(input int n);
        logic done;
        logic [7:0] q;
        for (int i = 0; i < n; i++) step(16'h0000, 1'b0, 8'h00, done, q);
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [7:0] d);
        logic done = 1'b0;
        logic [7:0] q;
        for (int i = 0; i < 16 && !done; i++) step({BASE[15:4], off}, 1'b1, d, done, q);
        check("write_done", done, 1'b1);
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [7:0] q);
        logic done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) step({BASE[15:4], off}, 1'b0, 8'h00, done, q);
        check("read_done", done, 1'b1);
    endtask

    // Assert reset between edges, check its immediate effect, release
    // shortly after the following rising edge.
    task automatic do_reset();
        res = 1'b1;
        #1;
        model_reset();
        check("rst_rdy", rdy, 1'b1);
        check("rst_irq", IRQ, 1'b1);
        check("rst_rd_data", rd_data, model_rd(add_bus));
        @(posedge clk);
        #2;
        res = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        logic [7:0] q;
        logic [15:0] a;
        logic [7:0] d;

        do_reset();

        // Reset in the middle of a stalled access
        step({BASE[15:4], 4'h4}, 1'b0, 8'h00, done, q);
        @(negedge clk);
        #2;
        do_reset();
        bus_read(4'h2, q); check("lat_lo_reset", q, 8'hFF);
        bus_read(4'h3, q); check("lat_hi_reset", q, 8'hFF);
        bus_read(4'h4, q); check("ctrl_reset", q, 8'h00);

        // Unselected address
        step(16'hD100, 1'b0, 8'h00, done, q);
        check("unsel_data", q, 8'h00);

        // One-shot
        bus_write(4'h2, 8'h03);
        bus_write(4'h3, 8'h00);
        bus_write(4'h4, 8'h05);
        idle(8);
        check("oneshot_irq", IRQ, 1'b0);
        bus_read(4'h4, q); check("oneshot_en_off", q, 8'h04);
        bus_read(4'h0, q); check("oneshot_cnt_zero", q, 8'h00);
        bus_write(4'h5, 8'h01);
        idle(3);
        check("oneshot_irq_clear", IRQ, 1'b1);

        // Continuous, with W1C writes landing on every phase of the period
        bus_write(4'h2, 8'h04);
        bus_write(4'h4, 8'h07);
        bus_write(4'h3, 8'h00);
        for (int i = 0; i < 12; i++) bus_write(4'h5, 8'h01);
        idle(12);

        // Snapshot coherence
        bus_write(4'h4, 8'h00);
        bus_write(4'h2, 8'hFF);
        bus_write(4'h3, 8'h12);
        bus_read(4'h0, q); check("snap_lo", q, 8'hFF);
        bus_write(4'h4, 8'h01);
        idle(300);
        bus_read(4'h1, q); check("snap_hi", q, 8'h12);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(7) != 0) a = {BASE[15:4], 4'($urandom_range(15))};
            else                        a = 16'($urandom);
            d = 8'($urandom);
            if (a[3:0] == 4'h3 && $urandom_range(3) != 0) d = 8'h00;
            if (a[3:0] == 4'h2 && $urandom_range(1) != 0) d = 8'($urandom_range(15));
            step(a, 1'($urandom), d, done, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
